// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation codes,
// FSM state encoding and the iteration counter width helper.
package ex_muldiv_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // The counter must hold NB_DATA itself, hence the +1.
    function automatic int cnt_width(input int nb_data);
        return $clog2(nb_data + 1);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Issue/result bundle between ID/EX, the hazard unit and the multiply/divide unit.
interface ex_muldiv_if #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 3
);
    logic               i_start;
    logic [NB_OP-1:0]   i_op;
    logic [NB_DATA-1:0] i_data_1;
    logic [NB_DATA-1:0] i_data_2;
    logic               i_flush;
    logic               o_busy;
    logic               o_done;
    logic [NB_DATA-1:0] o_hi;
    logic [NB_DATA-1:0] o_lo;

    modport master (
        output i_start, i_op, i_data_1, i_data_2, i_flush,
        input  o_busy, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_data_1, i_data_2, i_flush,
        output o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/ex_muldiv_iter.sv
// One iteration of the shift-add multiplier or restoring divider, working on
// unsigned magnitudes. The accumulator layout is {upper, lower}:
//   multiply: upper = partial product, lower = remaining multiplier bits
//   divide:   upper = partial remainder, lower = dividend bits / quotient bits
module ex_muldiv_iter #(
    parameter int NB_DATA = 32
) (
    input  logic                 is_div,
    input  logic [2*NB_DATA-1:0] acc,
    input  logic [NB_DATA-1:0]   operand,
    output logic [2*NB_DATA-1:0] acc_next
);

    logic [NB_DATA:0] mul_sum;
    logic [NB_DATA:0] div_trial;
    logic [NB_DATA:0] div_diff;

    // Compute both candidate steps and select by operation; the divider keeps
    // the trial remainder only when the subtraction does not borrow.
    always_comb begin
        mul_sum   = {1'b0, acc[2*NB_DATA-1:NB_DATA]}
                  + {1'b0, (acc[0] ? operand : {NB_DATA{1'b0}})};
        div_trial = acc[2*NB_DATA-1:NB_DATA-1];
        div_diff  = div_trial - {1'b0, operand};
        acc_next  = {mul_sum, acc[NB_DATA-1:1]};
        if (is_div) begin
            if (!div_diff[NB_DATA]) begin
                acc_next = {div_diff[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b1};
            end else begin
                acc_next = {div_trial[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit owning HI/LO. Signed operations run on
// magnitudes and get their signs restored in the FIX state.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    ex_muldiv_if.slave bus
);

    localparam int CNT_W = cnt_width(NB_DATA);

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     cnt;
    logic [2*NB_DATA-1:0] acc;
    logic [2*NB_DATA-1:0] acc_next;
    logic [NB_DATA-1:0]   operand;
    logic                 op_is_div;
    logic                 sign_a;
    logic                 sign_b;
    logic [NB_DATA-1:0]   hi_q;
    logic [NB_DATA-1:0]   lo_q;
    logic                 done_q;

    logic                 issue_ok;
    logic                 op_mult;
    logic                 op_multu;
    logic                 op_div;
    logic                 op_divu;
    logic                 op_mthi;
    logic                 op_mtlo;
    logic                 iter_op;
    logic                 signed_op;
    logic [NB_DATA-1:0]   mag_1;
    logic [NB_DATA-1:0]   mag_2;

    logic [2*NB_DATA-1:0] product;
    logic [NB_DATA-1:0]   quotient;
    logic [NB_DATA-1:0]   remainder;
    logic [NB_DATA-1:0]   res_hi;
    logic [NB_DATA-1:0]   res_lo;

    assign issue_ok  = (state == ST_IDLE) && bus.i_start && !bus.i_flush;
    assign op_mult   = (bus.i_op == NB_OP'(OP_MULT));
    assign op_multu  = (bus.i_op == NB_OP'(OP_MULTU));
    assign op_div    = (bus.i_op == NB_OP'(OP_DIV));
    assign op_divu   = (bus.i_op == NB_OP'(OP_DIVU));
    assign op_mthi   = (bus.i_op == NB_OP'(OP_MTHI));
    assign op_mtlo   = (bus.i_op == NB_OP'(OP_MTLO));
    assign iter_op   = op_mult | op_multu | op_div | op_divu;
    assign signed_op = op_mult | op_div;
    assign mag_1     = (signed_op && bus.i_data_1[NB_DATA-1]) ? -bus.i_data_1 : bus.i_data_1;
    assign mag_2     = (signed_op && bus.i_data_2[NB_DATA-1]) ? -bus.i_data_2 : bus.i_data_2;

    ex_muldiv_iter #(
        .NB_DATA (NB_DATA)
    ) u_iter (
        .is_div   (op_is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    // State register; reset may land mid-operation and always returns to IDLE.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: issue starts RUN, the last iteration moves to FIX,
    // and flush abandons any in-flight operation.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (issue_ok && iter_op) next_state = ST_RUN;
            ST_RUN: begin
                if (bus.i_flush) begin
                    next_state = ST_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    next_state = ST_FIX;
                end
            end
            ST_FIX:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Sign restoration and divide-by-zero override applied to the final accumulator.
    always_comb begin
        product   = (sign_a ^ sign_b) ? -acc : acc;
        quotient  = (sign_a ^ sign_b) ? -acc[NB_DATA-1:0] : acc[NB_DATA-1:0];
        remainder = sign_a ? -acc[2*NB_DATA-1:NB_DATA] : acc[2*NB_DATA-1:NB_DATA];
        res_hi    = product[2*NB_DATA-1:NB_DATA];
        res_lo    = product[NB_DATA-1:0];
        if (op_is_div) begin
            res_hi = remainder;
            res_lo = (operand == '0) ? {NB_DATA{1'b1}} : quotient;
        end
    end

    // Operand capture, per-cycle iteration, HI/LO writes and the done pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt       <= '0;
            acc       <= '0;
            operand   <= '0;
            op_is_div <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue_ok && iter_op) begin
                        op_is_div <= op_div | op_divu;
                        sign_a    <= signed_op & bus.i_data_1[NB_DATA-1];
                        sign_b    <= signed_op & bus.i_data_2[NB_DATA-1];
                        cnt       <= CNT_W'(NB_DATA);
                        if (op_div || op_divu) begin
                            acc     <= {{NB_DATA{1'b0}}, mag_1};
                            operand <= mag_2;
                        end else begin
                            acc     <= {{NB_DATA{1'b0}}, mag_2};
                            operand <= mag_1;
                        end
                    end else if (issue_ok && op_mthi) begin
                        hi_q <= bus.i_data_1;
                    end else if (issue_ok && op_mtlo) begin
                        lo_q <= bus.i_data_1;
                    end
                end
                ST_RUN: begin
                    if (bus.i_flush) begin
                        cnt <= '0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (!bus.i_flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign bus.o_busy = (state != ST_IDLE);
    assign bus.o_done = done_q;
    assign bus.o_hi   = hi_q;
    assign bus.o_lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed products/quotients, busy/done
// timing, ignored issues while busy, flush and asynchronous reset.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk;
    logic reset;

    int n_checks;
    int n_fails;
    int busy_len;
    int first_low;
    int done_cycle;
    int done_count;

    ex_muldiv_if #(.NB_DATA(32), .NB_OP(3)) bus ();

    ex_muldiv #(
        .NB_DATA (32),
        .NB_OP   (3)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Single-cycle issue; returns at the negedge of cycle 1.
    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_op     = op;
        bus.i_data_1 = a;
        bus.i_data_2 = b;
        bus.i_flush  = 1'b0;
        @(negedge clk);
        bus.i_start  = 1'b0;
    endtask

    // Issues at cycle 0 and watches 40 cycles, optionally injecting extra
    // issues at cycles 5 and 10 and a flush at flush_cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, input int flush_cycle);
        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_op     = op;
        bus.i_data_1 = a;
        bus.i_data_2 = b;
        bus.i_flush  = 1'b0;
        busy_len   = 0;
        first_low  = 0;
        done_cycle = 0;
        done_count = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.o_busy) busy_len++;
            else if (first_low == 0) first_low = c;
            if (bus.o_done) begin
                done_count++;
                if (done_cycle == 0) done_cycle = c;
            end
            bus.i_start = 1'b0;
            bus.i_flush = (c == flush_cycle);
            if (inject && c == 5) begin
                bus.i_start  = 1'b1;
                bus.i_op     = OP_MULTU;
                bus.i_data_1 = 32'd9;
                bus.i_data_2 = 32'd9;
            end
            if (inject && c == 10) begin
                bus.i_start  = 1'b1;
                bus.i_op     = OP_MTHI;
                bus.i_data_1 = 32'hDEAD;
            end
        end
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
        check_output({tag, "_hi"}, 64'(bus.o_hi), 64'(exp_hi));
        check_output({tag, "_lo"}, 64'(bus.o_lo), 64'(exp_lo));
        check_output({tag, "_busy_len"}, 64'(busy_len), 64'd33);
        check_output({tag, "_done_cycle"}, 64'(done_cycle), 64'd34);
        check_output({tag, "_done_count"}, 64'(done_count), 64'd1);
    endtask

    // Directed sequence.
    initial begin
        n_checks     = 0;
        n_fails      = 0;
        reset        = 1'b1;
        bus.i_start  = 1'b0;
        bus.i_op     = OP_NOP;
        bus.i_data_1 = '0;
        bus.i_data_2 = '0;
        bus.i_flush  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check_output("rst_busy", 64'(bus.o_busy), 64'd0);
        check_output("rst_done", 64'(bus.o_done), 64'd0);
        check_output("rst_hi", 64'(bus.o_hi), 64'd0);
        check_output("rst_lo", 64'(bus.o_lo), 64'd0);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        check_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        check_output("multu_first_low", 64'(first_low), 64'd34);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 0);
        check_op("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        check_op("mult_minmin", 32'h4000_0000, 32'h0000_0000);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        check_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
        check_op("div_negdivisor", 32'd1, 32'hFFFF_FFFD);

        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 0);
        check_op("divu", 32'd2, 32'd14);

        run_op(OP_DIVU, 32'd5, 32'd0, 1'b0, 0);
        check_op("divu_zero", 32'd5, 32'hFFFF_FFFF);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        check_op("div_overflow", 32'd0, 32'h8000_0000);

        apply_stimulus(OP_MTLO, 32'h1234, 32'd0);
        check_output("mtlo_lo", 64'(bus.o_lo), 64'h1234);
        check_output("mtlo_done", 64'(bus.o_done), 64'd0);
        check_output("mtlo_busy", 64'(bus.o_busy), 64'd0);

        run_op(OP_MULTU, 32'd3, 32'd5, 1'b1, 0);
        check_op("busy_ignore", 32'd0, 32'd15);

        apply_stimulus(OP_MTHI, 32'hAA, 32'd0);
        apply_stimulus(OP_MTLO, 32'hBB, 32'd0);
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 10);
        check_output("flush_busy_len", 64'(busy_len), 64'd10);
        check_output("flush_first_low", 64'(first_low), 64'd11);
        check_output("flush_done_count", 64'(done_count), 64'd0);
        check_output("flush_hi", 64'(bus.o_hi), 64'hAA);
        check_output("flush_lo", 64'(bus.o_lo), 64'hBB);

        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_op     = OP_MULTU;
        bus.i_data_1 = 32'd3;
        bus.i_data_2 = 32'd5;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        check_output("pre_reset_busy", 64'(bus.o_busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_output("async_rst_busy", 64'(bus.o_busy), 64'd0);
        check_output("async_rst_done", 64'(bus.o_done), 64'd0);
        check_output("async_rst_hi", 64'(bus.o_hi), 64'd0);
        check_output("async_rst_lo", 64'(bus.o_lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 0);
        check_op("post_reset_divu", 32'd2, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
